// File: rtl/ad9516_spi_arb_if.sv
// Requester-side bus of the AD9516 SPI arbiter: two request/ack ports, one per requester.
// master = requester side, slave = arbiter side.
interface ad9516_spi_arb_if;
   logic        r0_req;
   logic        r0_rd;
   logic [12:0] r0_addr;
   logic [7:0]  r0_wdata;
   logic        r0_ack;
   logic [7:0]  r0_rdata;
   logic        r1_req;
   logic        r1_rd;
   logic [12:0] r1_addr;
   logic [7:0]  r1_wdata;
   logic        r1_ack;
   logic [7:0]  r1_rdata;

   modport master (
      output r0_req, r0_rd, r0_addr, r0_wdata, r1_req, r1_rd, r1_addr, r1_wdata,
      input  r0_ack, r0_rdata, r1_ack, r1_rdata
   );

   modport slave (
      input  r0_req, r0_rd, r0_addr, r0_wdata, r1_req, r1_rd, r1_addr, r1_wdata,
      output r0_ack, r0_rdata, r1_ack, r1_rdata
   );
endinterface

// File: rtl/ad9516_spi_arb.sv
// Round-robin arbiter sharing the AD9516 serial control port between two requesters.
// Define AD9516_SPI_READBACK_EN to capture AD_SDO into rdata during read frames.
module ad9516_spi_arb #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   ad9516_spi_arb_if.slave req_if,
   output logic            busy,
   output logic            grant,
   output logic            AD_CS,
   output logic            AD_SCLK,
   output logic            AD_SDI,
   input  logic            AD_SDO
);
   // A parameter of 0 behaves as 1 so every counter still terminates.
   localparam logic [7:0] DIV_LAST = (CLK_DIV < 2) ? 8'd0 : 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = (CS_GAP < 2) ? 8'd0 : 8'(CS_GAP - 1);

   typedef enum logic [2:0] {IDLE, ARB, SHIFT_LO, SHIFT_HI, GAP} state_t;

   state_t      state, state_nxt;
   logic [7:0]  div_cnt, div_nxt, gap_cnt, gap_nxt;
   logic [4:0]  bit_cnt, bit_nxt;
   logic [23:0] shreg, shreg_nxt;
   logic        rr_last, rr_nxt, grant_nxt, busy_nxt;
   logic        cs_nxt, sclk_nxt, sdi_nxt;
   logic        ack0, ack1, ack0_nxt, ack1_nxt;
   logic        div_done, take, win, sel_rd, frame_done;
   logic [12:0] sel_addr;
   logic [7:0]  sel_wdata;

   assign div_done   = (div_cnt == DIV_LAST);
   assign take       = (state == ARB) && (req_if.r0_req || req_if.r1_req);
   assign win        = (req_if.r0_req && req_if.r1_req) ? ~rr_last : req_if.r1_req;
   assign sel_rd     = win ? req_if.r1_rd    : req_if.r0_rd;
   assign sel_addr   = win ? req_if.r1_addr  : req_if.r0_addr;
   assign sel_wdata  = win ? req_if.r1_wdata : req_if.r0_wdata;
   assign frame_done = (state == SHIFT_HI) && div_done && (bit_cnt == 5'd23);

   // Next-state logic; the pins are registered from the next state so they never glitch.
   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      gap_nxt   = gap_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      rr_nxt    = rr_last;
      grant_nxt = grant;
      busy_nxt  = busy;
      ack0_nxt  = 1'b0;
      ack1_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (req_if.r0_req || req_if.r1_req) state_nxt = ARB;
         end
         ARB: begin
            if (take) begin
               state_nxt = SHIFT_LO;
               rr_nxt    = win;
               grant_nxt = win;
               busy_nxt  = 1'b1;
               shreg_nxt = {sel_rd, 2'b00, sel_addr, sel_rd ? 8'h00 : sel_wdata};
               div_nxt   = 8'd0;
               bit_nxt   = 5'd0;
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT_LO: begin
            if (div_done) begin
               div_nxt   = 8'd0;
               state_nxt = SHIFT_HI;
            end else begin
               div_nxt = div_cnt + 8'd1;
            end
         end
         SHIFT_HI: begin
            if (!div_done) begin
               div_nxt = div_cnt + 8'd1;
            end else if (frame_done) begin
               div_nxt   = 8'd0;
               gap_nxt   = 8'd0;
               state_nxt = GAP;
               ack0_nxt  = ~grant;
               ack1_nxt  = grant;
            end else begin
               div_nxt   = 8'd0;
               bit_nxt   = bit_cnt + 5'd1;
               shreg_nxt = {shreg[22:0], 1'b0};
               state_nxt = SHIFT_LO;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else begin
               gap_nxt = gap_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      cs_nxt   = !((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI));
      sclk_nxt = (state_nxt == SHIFT_HI);
      sdi_nxt  = cs_nxt ? 1'b0 : shreg_nxt[23];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         div_cnt <= 8'd0;
         gap_cnt <= 8'd0;
         bit_cnt <= 5'd0;
         shreg   <= 24'd0;
         rr_last <= 1'b1;
         grant   <= 1'b0;
         busy    <= 1'b0;
         AD_CS   <= 1'b1;
         AD_SCLK <= 1'b0;
         AD_SDI  <= 1'b0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         gap_cnt <= gap_nxt;
         bit_cnt <= bit_nxt;
         shreg   <= shreg_nxt;
         rr_last <= rr_nxt;
         grant   <= grant_nxt;
         busy    <= busy_nxt;
         AD_CS   <= cs_nxt;
         AD_SCLK <= sclk_nxt;
         AD_SDI  <= sdi_nxt;
         ack0    <= ack0_nxt;
         ack1    <= ack1_nxt;
      end
   end

   assign req_if.r0_ack = ack0;
   assign req_if.r1_ack = ack1;

`ifdef AD9516_SPI_READBACK_EN
   logic       rd_lat;
   logic [7:0] rx_sh, rdata0, rdata1;

   // SDO is taken on the clk where SCLK rises, for the 8 data bits of a read only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_lat <= 1'b0;
         rx_sh  <= 8'h00;
         rdata0 <= 8'h00;
         rdata1 <= 8'h00;
      end else begin
         if (take) begin
            rd_lat <= sel_rd;
            rx_sh  <= 8'h00;
         end
         if (rd_lat && (state == SHIFT_LO) && div_done && (bit_cnt >= 5'd16)) begin
            rx_sh <= {rx_sh[6:0], AD_SDO};
         end
         if (frame_done) begin
            if (grant) rdata1 <= rx_sh;
            else       rdata0 <= rx_sh;
         end
      end
   end

   assign req_if.r0_rdata = rdata0;
   assign req_if.r1_rdata = rdata1;
`else
   logic unused_sdo;
   assign unused_sdo      = AD_SDO;
   assign req_if.r0_rdata = 8'h00;
   assign req_if.r1_rdata = 8'h00;
`endif
endmodule
